// File: rtl/oled_frame_sequencer_pkg.sv
// Shared constants and types for the OLED frame sequencer and its font ROM.
package oled_pkg;

  // SSD1306 panel geometry: 128 columns by 8 pages of 8 pixel rows.
  localparam int OLED_COLS   = 128;
  localparam int OLED_PAGES  = 8;
  localparam int FRAME_BYTES = OLED_COLS * OLED_PAGES;

  // Each digit cell is 8 columns wide.
  localparam int GLYPH_W = 8;

  // Any code above 9 renders as an empty cell.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    GAP,
    SEND,
    DONE
  } seq_state_t;

endpackage

// File: rtl/oled_frame_sequencer_if.sv
// Byte/strobe handshake between the frame sequencer and the SSD1306 driver.
interface oled_frame_sequencer_if;

  logic       drv_ready;
  logic [7:0] drv_data;
  logic       drv_write_stb;
  logic       drv_sync_stb;

  // Sequencer side: issues bytes and strobes, watches ready.
  modport master (
    input  drv_ready,
    output drv_data,
    output drv_write_stb,
    output drv_sync_stb
  );

  // Driver side: accepts bytes and strobes, reports ready.
  modport slave (
    output drv_ready,
    input  drv_data,
    input  drv_write_stb,
    input  drv_sync_stb
  );

endinterface

// File: rtl/oled_frame_sequencer_font_rom.sv
// 8x8 digit glyph ROM: column 0 and columns 6-7 are empty, columns 1-5 carry
// the classic 5x7 font. Codes above 9 return an empty column.
module font_rom_8x8 (
  input  logic [3:0] code,
  input  logic [2:0] gcol,
  output logic [7:0] glyph_byte
);

  // The five font columns of the selected digit, leftmost in the top byte.
  logic [39:0] font_cols;

  // Look up the 5x7 font columns for the digit code.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what keeps the tools from inferring a latch.
    font_cols = 40'h0;
    case (code)
      4'd0:    font_cols = 40'h3E_51_49_45_3E;
      4'd1:    font_cols = 40'h00_42_7F_40_00;
      4'd2:    font_cols = 40'h42_61_51_49_46;
      4'd3:    font_cols = 40'h21_41_45_4B_31;
      4'd4:    font_cols = 40'h18_14_12_7F_10;
      4'd5:    font_cols = 40'h27_45_45_45_39;
      4'd6:    font_cols = 40'h3C_4A_49_49_30;
      4'd7:    font_cols = 40'h01_71_09_05_03;
      4'd8:    font_cols = 40'h36_49_49_49_36;
      4'd9:    font_cols = 40'h06_49_49_29_1E;
      default: font_cols = 40'h0;
    endcase
  end

  // Pick one column of the 8-wide cell; the margins stay dark.
  always_comb begin
    glyph_byte = 8'h00;
    case (gcol)
      3'd1:    glyph_byte = font_cols[39:32];
      3'd2:    glyph_byte = font_cols[31:24];
      3'd3:    glyph_byte = font_cols[23:16];
      3'd4:    glyph_byte = font_cols[15:8];
      3'd5:    glyph_byte = font_cols[7:0];
      default: glyph_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Streams one full SSD1306 frame per request: a sync strobe followed by every
// display byte in page-major order. The snapshotted BCD digits are drawn as
// 8x8 glyphs on one text page; all other bytes are blank.
module oled_frame_sequencer
  import oled_pkg::*;
#(
  parameter int DIGITS_NUM = 6,
  parameter int TEXT_PAGE  = 3,
  parameter int TEXT_COL0  = 40,
  parameter int LZ_BLANK   = 1
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      frame_req,
  input  logic [4*DIGITS_NUM-1:0]   digits_in,
  oled_frame_sequencer_if.master    drv,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int FIELD_W = GLYPH_W * DIGITS_NUM;

  seq_state_t              state;
  logic [2:0]              page;
  logic [6:0]              col;
  logic                    last_q;
  logic                    pending;
  logic [4*DIGITS_NUM-1:0] digit_q;
  logic [7:0]              data_q;

  // Digit-field decode for the current (page, col).
  logic [7:0]              col_ext;
  logic [7:0]              field_off;
  logic                    in_field;
  logic [4:0]              digit_slot;
  logic [2:0]              glyph_col;
  logic [DIGITS_NUM-1:0]   lz_mask;
  logic                    lz_all_zero;
  logic [3:0]              sel_digit;
  logic                    sel_lz;
  logic [3:0]              glyph_code;
  logic [7:0]              font_byte;
  logic [7:0]              byte_next;

  assign col_ext    = {1'b0, col};
  assign field_off  = col_ext - 8'(TEXT_COL0);
  assign in_field   = (page == 3'(TEXT_PAGE)) &&
                      (col_ext >= 8'(TEXT_COL0)) &&
                      (field_off < 8'(FIELD_W));
  assign digit_slot = field_off[7:3];
  assign glyph_col  = field_off[2:0];

  // lz_mask[i] is set when digit i and every more significant digit are zero.
  always_comb begin
    lz_all_zero = 1'b1;
    lz_mask     = '0;
    for (int i = DIGITS_NUM - 1; i >= 0; i--) begin
      lz_all_zero = lz_all_zero && (digit_q[4*i +: 4] == 4'd0);
      lz_mask[i]  = lz_all_zero;
    end
  end

  // Select the digit under the current column; slot 0 is the MS digit.
  always_comb begin
    sel_digit = 4'd0;
    sel_lz    = 1'b0;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      if (i == DIGITS_NUM - 1 - int'(digit_slot)) begin
        sel_digit = digit_q[4*i +: 4];
        // The least significant digit is always shown, even when zero.
        sel_lz    = lz_mask[i] && (i != 0);
      end
    end
  end

  assign glyph_code = (!in_field || ((LZ_BLANK != 0) && sel_lz)) ? BLANK_CODE : sel_digit;

  font_rom_8x8 u_font (
    .code       (glyph_code),
    .gcol       (glyph_col),
    .glyph_byte (font_byte)
  );

  assign byte_next = in_field ? font_byte : 8'h00;

  // The driver qualifies a strobe with ready in the same cycle, so the strobes
  // are decoded from state and ready rather than registered a cycle late.
  assign drv.drv_sync_stb  = (state == SYNC) && drv.drv_ready;
  assign drv.drv_write_stb = (state == SEND) && drv.drv_ready;
  assign drv.drv_data      = data_q;

  // Frame sequencing FSM with page/column counters and registered status.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= IDLE;
      page       <= 3'd0;
      col        <= 7'd0;
      last_q     <= 1'b0;
      pending    <= 1'b0;
      // NOTE: the digit snapshot is reset with the rest of the state so a
      // frame started right after reset can never show stale digits.
      digit_q    <= '0;
      data_q     <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the pre-edge values of the others.
      frame_done <= 1'b0;

      // A request while a frame is in flight is remembered once.
      if (frame_req && (state inside {SYNC, GAP, SEND})) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_req) begin
            digit_q <= digits_in;
            page    <= 3'd0;
            col     <= 7'd0;
            last_q  <= 1'b0;
            busy    <= 1'b1;
            state   <= SYNC;
          end
        end

        SYNC: begin
          if (drv.drv_ready) begin
            state <= GAP;
          end
        end

        GAP: begin
          if (last_q) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            // Present the next byte before SEND so it is valid with the strobe.
            data_q <= byte_next;
            state  <= SEND;
          end
        end

        SEND: begin
          if (drv.drv_ready) begin
            col <= col + 7'd1;
            if (col == 7'(OLED_COLS - 1)) begin
              page <= page + 3'd1;
              if (page == 3'(OLED_PAGES - 1)) begin
                last_q <= 1'b1;
              end
            end
            state <= GAP;
          end
        end

        DONE: begin
          // A remembered request (or one arriving right now) chains directly
          // into the next frame without an IDLE cycle.
          if (pending || frame_req) begin
            pending <= 1'b0;
            digit_q <= digits_in;
            page    <= 3'd0;
            col     <= 7'd0;
            last_q  <= 1'b0;
            busy    <= 1'b1;
            state   <= SYNC;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Self-checking bench for oled_frame_sequencer: stimulus pushes the expected
// strobe/byte/done sequence of each frame into a scoreboard queue; a monitor
// pops and compares on every strobe and frame_done pulse.
module tb_oled_frame_sequencer;

  localparam int K_SYNC = 0;
  localparam int K_BYTE = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int data;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        frame_req;
  logic [23:0] digits_in;
  logic        busy;
  logic        frame_done;

  oled_frame_sequencer_if drv_if ();

  oled_frame_sequencer #(
    .DIGITS_NUM (6),
    .TEXT_PAGE  (3),
    .TEXT_COL0  (40),
    .LZ_BLANK   (1)
  ) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .frame_req  (frame_req),
    .digits_in  (digits_in),
    .drv        (drv_if.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial forever #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   frame_mem [1024];
  int   save_mem  [1024];
  int   byte_idx    = 0;
  int   sync_count  = 0;
  int   write_count = 0;
  int   done_count  = 0;
  int   sync_cycle  = 0;
  int   done_cycle  = 0;
  int   req_cycle   = 0;
  bit   prev_stb    = 1'b0;
  bit   rand_ready  = 1'b0;

  // 5-column font of the digits, straight from the 5x7 character set.
  int font5 [10][5] = '{
    '{'h3E, 'h51, 'h49, 'h45, 'h3E},
    '{'h00, 'h42, 'h7F, 'h40, 'h00},
    '{'h42, 'h61, 'h51, 'h49, 'h46},
    '{'h21, 'h41, 'h45, 'h4B, 'h31},
    '{'h18, 'h14, 'h12, 'h7F, 'h10},
    '{'h27, 'h45, 'h45, 'h45, 'h39},
    '{'h3C, 'h4A, 'h49, 'h49, 'h30},
    '{'h01, 'h71, 'h09, 'h05, 'h03},
    '{'h36, 'h49, 'h49, 'h49, 'h36},
    '{'h06, 'h49, 'h49, 'h29, 'h1E}
  };

  int one_g  [8] = '{'h00, 'h00, 'h42, 'h7F, 'h40, 'h00, 'h00, 'h00};
  int zero_g [8] = '{'h00, 'h3E, 'h51, 'h49, 'h45, 'h3E, 'h00, 'h00};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the byte shown at (p, c) for digit word d.
  function automatic int model_byte(input logic [23:0] d, input int p, input int c);
    int off, k, g, code;
    off = c - 40;
    if (p != 3 || off < 0 || off >= 48) return 0;
    k    = 5 - off / 8;
    g    = off % 8;
    code = int'((d >> (4 * k)) & 24'hF);
    // Leading zero: this digit and all above it read as the number zero.
    if (k != 0 && (d >> (4 * k)) == 24'h0) return 0;
    if (code > 9 || g < 1 || g > 5) return 0;
    return font5[code][g-1];
  endfunction

  task automatic push_frame(input logic [23:0] d);
    exp_t e;
    e.kind = K_SYNC; e.data = 0;
    exp_q.push_back(e);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 128; c++) begin
        e.kind = K_BYTE;
        e.data = model_byte(d, p, c);
        exp_q.push_back(e);
      end
    end
    e.kind = K_DONE; e.data = 0;
    exp_q.push_back(e);
  endtask

  task automatic send_req();
    @(posedge clk_in);
    #1 frame_req = 1'b1;
    req_cycle = cyc;
    @(posedge clk_in);
    #1 frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int budget = 0;
    while (done_count < target && budget < 60000) begin
      @(negedge clk_in); #1;
      budget++;
    end
    check("frame_wait_timeout", int'(done_count >= target), 1);
  endtask

  task automatic wait_writes(input int target);
    int budget = 0;
    while (write_count < target && budget < 60000) begin
      @(negedge clk_in); #1;
      budget++;
    end
    check("write_wait_timeout", int'(write_count >= target), 1);
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] d;
    int lead;
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    end
    lead = $urandom_range(0, 5);
    for (int i = 0; i < lead; i++) d[4*(5-i) +: 4] = 4'd0;
    return d;
  endfunction

  // Driver model for ready: constant high, or random bursts with 0..20 low cycles.
  initial begin
    int low_left  = 0;
    int high_left = 0;
    drv_if.drv_ready = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rand_ready) begin
        drv_if.drv_ready = 1'b1;
      end else if (low_left > 0) begin
        drv_if.drv_ready = 1'b0;
        low_left--;
      end else if (high_left > 0) begin
        drv_if.drv_ready = 1'b1;
        high_left--;
      end else begin
        high_left = $urandom_range(0, 3);
        low_left  = $urandom_range(0, 20);
        drv_if.drv_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every strobe and frame_done pulse against the scoreboard.
  initial begin
    exp_t e;
    bit   s, w;
    forever begin
      @(negedge clk_in);
      s = drv_if.drv_sync_stb;
      w = drv_if.drv_write_stb;
      if (s || w) begin
        check("stb_exclusive", int'(s && w), 0);
        check("stb_back_to_back", int'(prev_stb), 0);
        check("stb_without_ready", int'(drv_if.drv_ready), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind", s ? K_SYNC : K_BYTE, e.kind);
          if (w && e.kind == K_BYTE) check("sb_data", int'(drv_if.drv_data), e.data);
        end
        if (s) begin
          sync_count++;
          sync_cycle = cyc;
          byte_idx   = 0;
        end
        if (w) begin
          if (byte_idx < 1024) frame_mem[byte_idx] = int'(drv_if.drv_data);
          byte_idx++;
          write_count++;
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_done_kind", K_DONE, e.kind);
        end
        done_count++;
        done_cycle = cyc;
      end
      prev_stb = s || w;
    end
  end

  // Stimulus.
  initial begin
    int s0, w0, d0, d1, nz;
    logic [23:0] rd;

    reset_in  = 1'b1;
    frame_req = 1'b0;
    digits_in = 24'h0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_sync_stb", int'(drv_if.drv_sync_stb), 0);
    check("rst_write_stb", int'(drv_if.drv_write_stb), 0);
    check("rst_data", int'(drv_if.drv_data), 0);
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Full frame, ready held high, digits 000001: counts, latency, glyphs.
    digits_in = 24'h000001;
    s0 = sync_count; w0 = write_count; d0 = done_count;
    push_frame(digits_in);
    send_req();
    repeat (5) @(negedge clk_in);
    check("busy_in_frame", int'(busy), 1);
    wait_frames(d0 + 1);
    check("t1_sync_latency", sync_cycle - req_cycle, 1);
    check("t1_frame_latency", done_cycle - req_cycle, 2051);
    check("t1_sync_count", sync_count - s0, 1);
    check("t1_write_count", write_count - w0, 1024);
    check("busy_at_done", int'(busy), 0);
    nz = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i >= 3*128 + 80 && i <= 3*128 + 87)
        check("t2_glyph_one", frame_mem[i], one_g[i - (3*128 + 80)]);
      else if (frame_mem[i] != 0)
        nz++;
    end
    check("t2_blank_bytes", nz, 0);
    for (int i = 0; i < 1024; i++) save_mem[i] = frame_mem[i];
    @(negedge clk_in);
    check("busy_idle", int'(busy), 0);

    // MS digit nonzero: no zero gets blanked.
    digits_in = 24'h100000;
    d0 = done_count;
    push_frame(digits_in);
    send_req();
    wait_frames(d0 + 1);
    for (int c = 40; c < 48; c++) check("t3_glyph_one", frame_mem[3*128 + c], one_g[c - 40]);
    for (int c = 48; c < 88; c++) check("t3_glyph_zero", frame_mem[3*128 + c], zero_g[(c - 48) % 8]);

    // Snapshot plus pending: two extra requests give exactly one chained frame.
    digits_in = 24'h000907;
    s0 = sync_count; w0 = write_count; d0 = done_count;
    push_frame(24'h000907);
    send_req();
    wait_writes(w0 + 300);
    digits_in = 24'h999999;
    push_frame(24'h999999);
    send_req();
    repeat (100) @(posedge clk_in);
    send_req();
    wait_frames(d0 + 1);
    d1 = done_cycle;
    wait_frames(d0 + 2);
    check("t4_chain_no_idle", sync_cycle - d1, 1);
    repeat (50) @(negedge clk_in);
    check("t4_sync_count", sync_count - s0, 2);
    check("t4_done_count", done_count - d0, 2);

    // Random ready: byte order identical to the 000001 frame.
    rand_ready = 1'b1;
    digits_in  = 24'h000001;
    d0 = done_count;
    push_frame(digits_in);
    send_req();
    wait_frames(d0 + 1);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (frame_mem[i] != save_mem[i]) nz++;
    check("t5_order_vs_t2", nz, 0);
    rd = rand_digits();
    digits_in = rd;
    d0 = done_count;
    push_frame(rd);
    send_req();
    wait_frames(d0 + 1);
    rand_ready = 1'b0;
    repeat (3) @(negedge clk_in);

    // Asynchronous reset at byte 500, between clock edges.
    digits_in = 24'h000001;
    w0 = write_count;
    push_frame(digits_in);
    send_req();
    wait_writes(w0 + 500);
    check("t6_stb_before_rst", int'(drv_if.drv_write_stb), 1);
    #1 reset_in = 1'b1;
    #1;
    check("t6_rst_write_stb", int'(drv_if.drv_write_stb), 0);
    check("t6_rst_sync_stb", int'(drv_if.drv_sync_stb), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(frame_done), 0);
    check("t6_rst_data", int'(drv_if.drv_data), 0);
    exp_q.delete();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("t6_no_stb_in_rst", int'(drv_if.drv_write_stb || drv_if.drv_sync_stb), 0);
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rd = rand_digits();
    digits_in = rd;
    d0 = done_count; s0 = sync_count;
    push_frame(rd);
    send_req();
    wait_frames(d0 + 1);
    check("t6_restart_sync", sync_count - s0, 1);
    check("t6_restart_latency", sync_cycle - req_cycle, 1);

    repeat (5) @(negedge clk_in);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
